// File: rtl/c5_bus_mux_fwd_if.sv
// c5_bus_mux_fwd_if: operand/forwarding/flow-control bundle between regfile read and execute.
interface c5_bus_mux_fwd_if #(
    parameter int WIDTH = 32,
    parameter int RADDR = 5,
    parameter int CNT_W = 8
);
    logic             I_valid;
    logic             O_ready;
    logic [15:0]      I_imm_in;
    logic [WIDTH-3:0] I_c_pc;
    logic [WIDTH-1:0] I_reg_source;
    logic [RADDR-1:0] I_rs_addr;
    logic [WIDTH-1:0] I_reg_target;
    logic [RADDR-1:0] I_rt_addr;
    logic [1:0]       I_a_mux;
    logic [1:0]       I_b_mux;
    logic [2:0]       I_branch_func;
    logic             I_ex_we;
    logic [RADDR-1:0] I_ex_addr;
    logic [WIDTH-1:0] I_ex_data;
    logic             I_mem_we;
    logic [RADDR-1:0] I_mem_addr;
    logic [WIDTH-1:0] I_mem_data;
    logic             I_mem_pending;
    logic             O_valid;
    logic             I_ready;
    logic [WIDTH-1:0] O_a_out;
    logic [WIDTH-1:0] O_b_out;
    logic             O_take_branch;
    logic [1:0]       O_fwd_a;
    logic [1:0]       O_fwd_b;
    logic [CNT_W-1:0] O_stall_cnt;
    modport master (
        output I_valid, I_imm_in, I_c_pc, I_reg_source, I_rs_addr, I_reg_target, I_rt_addr,
               I_a_mux, I_b_mux, I_branch_func, I_ex_we, I_ex_addr, I_ex_data,
               I_mem_we, I_mem_addr, I_mem_data, I_mem_pending, I_ready,
        input  O_ready, O_valid, O_a_out, O_b_out, O_take_branch, O_fwd_a, O_fwd_b, O_stall_cnt
    );
    modport slave (
        input  I_valid, I_imm_in, I_c_pc, I_reg_source, I_rs_addr, I_reg_target, I_rt_addr,
               I_a_mux, I_b_mux, I_branch_func, I_ex_we, I_ex_addr, I_ex_data,
               I_mem_we, I_mem_addr, I_mem_data, I_mem_pending, I_ready,
        output O_ready, O_valid, O_a_out, O_b_out, O_take_branch, O_fwd_a, O_fwd_b, O_stall_cnt
    );
endinterface

// File: rtl/c5_bus_mux_fwd.sv
// c5_bus_mux_fwd: registered operand/branch mux with EX/MEM forwarding, load-use stall and valid/ready output.
module c5_bus_mux_fwd #(
    parameter int WIDTH  = 32,
    parameter int RADDR  = 5,
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 8
) (
    input logic I_clk,
    input logic I_reset,
    c5_bus_mux_fwd_if.slave bus
);
    localparam logic [1:0] A_FROM_REG_SOURCE = 2'd0, A_FROM_IMM10_6 = 2'd1;
    localparam logic [1:0] B_FROM_REG_TARGET = 2'd0, B_FROM_IMM = 2'd1,
                           B_FROM_SIGNED_IMM = 2'd2, B_FROM_IMMX4 = 2'd3;
    localparam logic [2:0] BRANCH_NO = 3'd0, BRANCH_LTZ = 3'd1, BRANCH_LEZ = 3'd2, BRANCH_EQ = 3'd3,
                           BRANCH_NE = 3'd4, BRANCH_GEZ = 3'd5, BRANCH_GTZ = 3'd6, BRANCH_YES = 3'd7;

    logic             valid_q, valid_d, take_q, take_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, rs_f, rt_f;
    logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ex_rs, ex_rt, mem_rs, mem_rt, rs_used, rt_used, hazard, ready, xfer;
    logic signed [15:0]      simm;
    logic signed [17:0]      simm4;
    logic signed [WIDTH-1:0] sx, sx4;

    always_comb begin
        ex_rs   = FWD_EN && bus.I_ex_we && bus.I_ex_addr == bus.I_rs_addr && bus.I_rs_addr != '0;
        ex_rt   = FWD_EN && bus.I_ex_we && bus.I_ex_addr == bus.I_rt_addr && bus.I_rt_addr != '0;
        mem_rs  = FWD_EN && bus.I_mem_we && bus.I_mem_addr == bus.I_rs_addr && bus.I_rs_addr != '0;
        mem_rt  = FWD_EN && bus.I_mem_we && bus.I_mem_addr == bus.I_rt_addr && bus.I_rt_addr != '0;
        rs_f    = ex_rs ? bus.I_ex_data : mem_rs ? bus.I_mem_data : bus.I_reg_source;
        rt_f    = ex_rt ? bus.I_ex_data : mem_rt ? bus.I_mem_data : bus.I_reg_target;
        rs_used = bus.I_a_mux == A_FROM_REG_SOURCE ||
                  (bus.I_branch_func != BRANCH_YES && bus.I_branch_func != BRANCH_NO);
        rt_used = bus.I_b_mux == B_FROM_REG_TARGET ||
                  bus.I_branch_func == BRANCH_EQ || bus.I_branch_func == BRANCH_NE;
        // An EX match shadows the pending load for that operand, so only a MEM-selected operand stalls.
        hazard  = bus.I_mem_pending && ((rs_used && mem_rs && !ex_rs) || (rt_used && mem_rt && !ex_rt));
        ready   = !hazard && (!valid_q || bus.I_ready);
        xfer    = bus.I_valid && ready;
        simm    = bus.I_imm_in;
        simm4   = {bus.I_imm_in, 2'b00};
        sx      = simm;
        sx4     = simm4;
        case (bus.I_a_mux)
            A_FROM_REG_SOURCE: a_d = rs_f;
            A_FROM_IMM10_6:    a_d = WIDTH'(bus.I_imm_in[10:6]);
            default:           a_d = {bus.I_c_pc, 2'b00};
        endcase
        case (bus.I_b_mux)
            B_FROM_IMM:        b_d = WIDTH'(bus.I_imm_in);
            B_FROM_SIGNED_IMM: b_d = sx;
            B_FROM_IMMX4:      b_d = sx4;
            default:           b_d = rt_f;
        endcase
        case (bus.I_branch_func)
            BRANCH_LTZ: take_d = rs_f[WIDTH-1];
            BRANCH_LEZ: take_d = rs_f[WIDTH-1] | (rs_f == '0);
            BRANCH_EQ:  take_d = rs_f == rt_f;
            BRANCH_NE:  take_d = rs_f != rt_f;
            BRANCH_GEZ: take_d = !rs_f[WIDTH-1];
            BRANCH_GTZ: take_d = !rs_f[WIDTH-1] & (rs_f != '0);
            BRANCH_YES: take_d = 1'b1;
            default:    take_d = 1'b0;
        endcase
        fwd_a_d = !rs_used ? 2'd0 : ex_rs ? 2'd1 : mem_rs ? 2'd2 : 2'd0;
        fwd_b_d = !rt_used ? 2'd0 : ex_rt ? 2'd1 : mem_rt ? 2'd2 : 2'd0;
        valid_d = xfer ? 1'b1 : (valid_q && bus.I_ready) ? 1'b0 : valid_q;
        cnt_d   = (bus.I_valid && hazard && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            take_q  <= 1'b0;
            fwd_a_q <= '0;
            fwd_b_q <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            if (xfer) begin
                a_q     <= a_d;
                b_q     <= b_d;
                take_q  <= take_d;
                fwd_a_q <= fwd_a_d;
                fwd_b_q <= fwd_b_d;
            end
        end
    end

    assign bus.O_ready       = ready;
    assign bus.O_valid       = valid_q;
    assign bus.O_a_out       = a_q;
    assign bus.O_b_out       = b_q;
    assign bus.O_take_branch = take_q;
    assign bus.O_fwd_a       = fwd_a_q;
    assign bus.O_fwd_b       = fwd_b_q;
    assign bus.O_stall_cnt   = cnt_q;
endmodule
